// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: compacts up to four enabled I-Cache lanes per cycle
// into a circular buffer and presents two in-order slots. Optional IQ_PERF_EN adds a stall counter.
module fetch_inst_queue #(
  parameter int DEPTH     = 16,
  parameter int STOP_FREE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IC_valid_i,
  input  logic [31:0]  IC_VAddr_i,
  input  logic [127:0] IC_inst_i,
  input  logic [3:0]   IC_instEnable_i,
  input  logic         IC_hasException_i,
  input  logic [4:0]   IC_ExcCode_i,
  input  logic         IC_needDelaySlot_i,
  input  logic         flush_i,
  input  logic [1:0]   ID_popNum_i,
  output logic [1:0]   IQ_valid_o,
  output logic [31:0]  IQ_inst0_o,
  output logic [31:0]  IQ_inst1_o,
  output logic [31:0]  IQ_pc0_o,
  output logic [31:0]  IQ_pc1_o,
  output logic [1:0]   IQ_hasExc_o,
  output logic [4:0]   IQ_excCode0_o,
  output logic [4:0]   IQ_excCode1_o,
  output logic [1:0]   IQ_isDelaySlot_o,
  output logic         IQ_stopFetch_o,
  output logic         IQ_overflow_o
`ifdef IQ_PERF_EN
  ,output logic [31:0] IQ_stallCycles_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] STOP_W  = (AW+1)'(STOP_FREE);

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  logic [31:0] r_inst [DEPTH];
  logic [31:0] r_pc   [DEPTH];
  logic        r_exc  [DEPTH];
  logic [4:0]  r_code [DEPTH];
  logic        r_ds   [DEPTH];

  logic [AW:0] r_head, r_tail, r_count;
  logic        r_overflow;

  logic [2:0]    w_n;
  logic [AW:0]   w_free;
  logic          w_push, w_drop;
  logic [1:0]    w_req, w_pop;
  logic [1:0]    w_off [4];
  logic [AW-1:0] w_idx [4];
  logic [1:0]    w_low;
  logic [31:0]   w_exc_pc;
  logic [AW-1:0] w_h0, w_h1;

  // Push size, space check, pop clamp and per-lane compaction targets
  always_comb begin
    w_n    = IC_hasException_i ? 3'd1 : popcount4(IC_instEnable_i);
    w_free = DEPTH_W - r_count;
    w_push = IC_valid_i && ((AW+1)'(w_n) <= w_free);
    w_drop = IC_valid_i && !((AW+1)'(w_n) <= w_free);
    w_req  = (ID_popNum_i == 2'd3) ? 2'd2 : ID_popNum_i;
    if (r_count < (AW+1)'(w_req)) begin
      w_pop = r_count[1:0];
    end else begin
      w_pop = w_req;
    end
    w_off[0] = 2'd0;
    w_off[1] = {1'b0, IC_instEnable_i[0]};
    w_off[2] = w_off[1] + {1'b0, IC_instEnable_i[1]};
    w_off[3] = w_off[2] + {1'b0, IC_instEnable_i[2]};
    for (int k = 0; k < 4; k++) w_idx[k] = r_tail[AW-1:0] + AW'(w_off[k]);
    if (IC_instEnable_i[0]) begin
      w_low = 2'd0;
    end else if (IC_instEnable_i[1]) begin
      w_low = 2'd1;
    end else if (IC_instEnable_i[2]) begin
      w_low = 2'd2;
    end else if (IC_instEnable_i[3]) begin
      w_low = 2'd3;
    end else begin
      w_low = 2'd0;
    end
    w_exc_pc = IC_VAddr_i + {28'd0, w_low, 2'b00};
  end

  // Entry storage; an exception packet collapses to one tagged entry with no delay-slot mark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= 32'd0;
        r_pc[i]   <= 32'd0;
        r_exc[i]  <= 1'b0;
        r_code[i] <= 5'd0;
        r_ds[i]   <= 1'b0;
      end
    end else if (w_push && !flush_i) begin
      if (IC_hasException_i) begin
        r_inst[w_idx[0]] <= 32'd0;
        r_pc[w_idx[0]]   <= w_exc_pc;
        r_exc[w_idx[0]]  <= 1'b1;
        r_code[w_idx[0]] <= IC_ExcCode_i;
        r_ds[w_idx[0]]   <= 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (IC_instEnable_i[k]) begin
            r_inst[w_idx[k]] <= IC_inst_i[32*k +: 32];
            r_pc[w_idx[k]]   <= IC_VAddr_i + (32'(k) << 2);
            r_exc[w_idx[k]]  <= 1'b0;
            r_code[w_idx[k]] <= 5'd0;
            r_ds[w_idx[k]]   <= IC_needDelaySlot_i && (w_off[k] == 2'd0);
          end
        end
      end
    end
  end

  // Pointer, occupancy and sticky overflow state; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + (AW+1)'(w_pop);
      r_tail  <= r_tail + (AW+1)'(w_push ? w_n : 3'd0);
      r_count <= r_count + (AW+1)'(w_push ? w_n : 3'd0) - (AW+1)'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Output slots read head and head+1, zeroed while invalid
  always_comb begin
    w_h0             = r_head[AW-1:0];
    w_h1             = w_h0 + AW'(1);
    IQ_valid_o       = {r_count >= (AW+1)'(2), r_count >= (AW+1)'(1)};
    IQ_inst0_o       = 32'd0;
    IQ_pc0_o         = 32'd0;
    IQ_excCode0_o    = 5'd0;
    IQ_inst1_o       = 32'd0;
    IQ_pc1_o         = 32'd0;
    IQ_excCode1_o    = 5'd0;
    IQ_hasExc_o      = 2'b00;
    IQ_isDelaySlot_o = 2'b00;
    if (IQ_valid_o[0]) begin
      IQ_inst0_o          = r_inst[w_h0];
      IQ_pc0_o            = r_pc[w_h0];
      IQ_excCode0_o       = r_code[w_h0];
      IQ_hasExc_o[0]      = r_exc[w_h0];
      IQ_isDelaySlot_o[0] = r_ds[w_h0];
    end else begin
      IQ_inst0_o = 32'd0;
    end
    if (IQ_valid_o[1]) begin
      IQ_inst1_o          = r_inst[w_h1];
      IQ_pc1_o            = r_pc[w_h1];
      IQ_excCode1_o       = r_code[w_h1];
      IQ_hasExc_o[1]      = r_exc[w_h1];
      IQ_isDelaySlot_o[1] = r_ds[w_h1];
    end else begin
      IQ_inst1_o = 32'd0;
    end
    IQ_stopFetch_o = (DEPTH_W - r_count) < STOP_W;
    IQ_overflow_o  = r_overflow;
  end

`ifdef IQ_PERF_EN
  logic [31:0] r_stall;

  // Free-running stall counter, deliberately untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= 32'd0;
    end else if (IQ_stopFetch_o) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign IQ_stallCycles_o = r_stall;
`endif

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized self-checking bench for fetch_inst_queue against a queue-based reference model.
module tb_fetch_inst_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         IC_valid_i;
  logic [31:0]  IC_VAddr_i;
  logic [127:0] IC_inst_i;
  logic [3:0]   IC_instEnable_i;
  logic         IC_hasException_i;
  logic [4:0]   IC_ExcCode_i;
  logic         IC_needDelaySlot_i;
  logic         flush_i;
  logic [1:0]   ID_popNum_i;
  logic [1:0]   IQ_valid_o;
  logic [31:0]  IQ_inst0_o, IQ_inst1_o, IQ_pc0_o, IQ_pc1_o;
  logic [1:0]   IQ_hasExc_o;
  logic [4:0]   IQ_excCode0_o, IQ_excCode1_o;
  logic [1:0]   IQ_isDelaySlot_o;
  logic         IQ_stopFetch_o;
  logic         IQ_overflow_o;
`ifdef IQ_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  fetch_inst_queue dut (
    .clk(clk), .rst(rst),
    .IC_valid_i(IC_valid_i), .IC_VAddr_i(IC_VAddr_i), .IC_inst_i(IC_inst_i),
    .IC_instEnable_i(IC_instEnable_i), .IC_hasException_i(IC_hasException_i),
    .IC_ExcCode_i(IC_ExcCode_i), .IC_needDelaySlot_i(IC_needDelaySlot_i),
    .flush_i(flush_i), .ID_popNum_i(ID_popNum_i),
    .IQ_valid_o(IQ_valid_o), .IQ_inst0_o(IQ_inst0_o), .IQ_inst1_o(IQ_inst1_o),
    .IQ_pc0_o(IQ_pc0_o), .IQ_pc1_o(IQ_pc1_o), .IQ_hasExc_o(IQ_hasExc_o),
    .IQ_excCode0_o(IQ_excCode0_o), .IQ_excCode1_o(IQ_excCode1_o),
    .IQ_isDelaySlot_o(IQ_isDelaySlot_o), .IQ_stopFetch_o(IQ_stopFetch_o),
    .IQ_overflow_o(IQ_overflow_o)
`ifdef IQ_PERF_EN
    ,.IQ_stallCycles_o(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic        ds;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    ent_t e0, e1;
    int sz;
    sz = q.size();
    e0 = '{inst: 32'd0, pc: 32'd0, exc: 1'b0, code: 5'd0, ds: 1'b0};
    e1 = e0;
    if (sz >= 1) e0 = q[0];
    if (sz >= 2) e1 = q[1];
    check_val("valid", {30'd0, IQ_valid_o}, {30'd0, (sz >= 2), (sz >= 1)});
    check_val("inst0", IQ_inst0_o, e0.inst);
    check_val("pc0", IQ_pc0_o, e0.pc);
    check_val("inst1", IQ_inst1_o, e1.inst);
    check_val("pc1", IQ_pc1_o, e1.pc);
    check_val("hasExc", {30'd0, IQ_hasExc_o}, {30'd0, e1.exc, e0.exc});
    check_val("code0", {27'd0, IQ_excCode0_o}, {27'd0, e0.code});
    check_val("code1", {27'd0, IQ_excCode1_o}, {27'd0, e1.code});
    check_val("isDS", {30'd0, IQ_isDelaySlot_o}, {30'd0, e1.ds, e0.ds});
    check_val("stopFetch", {31'd0, IQ_stopFetch_o}, {31'd0, ((16 - sz) < 8)});
    check_val("overflow", {31'd0, IQ_overflow_o}, {31'd0, m_ovf});
  endtask

  // Reference behaviour: drop-or-append whole packets, pop up to two from the front
  task automatic model_step();
    ent_t add[$];
    ent_t e;
    int sz, n, p, low;
    bit first;
    if (flush_i) begin
      q.delete();
    end else if (!rst) begin
      sz = q.size();
      n  = IC_hasException_i ? 1 : $countones(IC_instEnable_i);
      if (IC_valid_i) begin
        if (n <= 16 - sz) begin
          if (IC_hasException_i) begin
            low = 0;
            for (int k = 3; k >= 0; k--) if (IC_instEnable_i[k]) low = k;
            e = '{inst: 32'd0, pc: IC_VAddr_i + 32'(4 * low), exc: 1'b1,
                  code: IC_ExcCode_i, ds: 1'b0};
            add.push_back(e);
          end else begin
            first = 1'b1;
            for (int k = 0; k < 4; k++) begin
              if (IC_instEnable_i[k]) begin
                e = '{inst: IC_inst_i[32*k +: 32], pc: IC_VAddr_i + 32'(4 * k), exc: 1'b0,
                      code: 5'd0, ds: first && IC_needDelaySlot_i};
                add.push_back(e);
                first = 1'b0;
              end
            end
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      p = int'(ID_popNum_i);
      if (p > 2) p = 2;
      if (p > sz) p = sz;
      repeat (p) void'(q.pop_front());
      foreach (add[i]) q.push_back(add[i]);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] base, input logic [3:0] m,
                     input logic ex, input logic [4:0] code, input logic ds,
                     input logic fl, input logic [1:0] pop);
    IC_valid_i         = v;
    IC_VAddr_i         = base;
    IC_inst_i          = {$urandom, $urandom, $urandom, $urandom};
    IC_instEnable_i    = m;
    IC_hasException_i  = ex;
    IC_ExcCode_i       = code;
    IC_needDelaySlot_i = ds;
    flush_i            = fl;
    ID_popNum_i        = pop;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] rb;
    rst = 1'b1;
    IC_valid_i = 1'b0; IC_VAddr_i = 32'd0; IC_inst_i = 128'd0; IC_instEnable_i = 4'd0;
    IC_hasException_i = 1'b0; IC_ExcCode_i = 5'd0; IC_needDelaySlot_i = 1'b0;
    flush_i = 1'b0; ID_popNum_i = 2'd0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch drained two per cycle
    cyc(1'b1, 32'h1FC00000, 4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    check_val("tp1_pc0", IQ_pc0_o, 32'h1FC00000);
    check_val("tp1_pc1", IQ_pc1_o, 32'h1FC00004);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2);
    check_val("tp1_pc0b", IQ_pc0_o, 32'h1FC00008);
    check_val("tp1_pc1b", IQ_pc1_o, 32'h1FC0000C);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2);
    check_val("tp1_empty", {30'd0, IQ_valid_o}, 32'd0);

    // Sparse mask with delay slot
    cyc(1'b1, 32'h00400020, 4'b1010, 1'b0, 5'd0, 1'b1, 1'b0, 2'd0);
    check_val("tp2_pc0", IQ_pc0_o, 32'h00400024);
    check_val("tp2_ds", {30'd0, IQ_isDelaySlot_o}, 32'd1);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd3);

    // Fill to full then overflow
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h00001000 + 32'(16 * i), 4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    check_val("tp3_ovf", {31'd0, IQ_overflow_o}, 32'd1);
    check_val("tp3_stop", {31'd0, IQ_stopFetch_o}, 32'd1);
    cyc(1'b1, 32'h00002000, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd0);

    // Flush with concurrent push and pop at count 5
    cyc(1'b1, 32'h00003000, 4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 32'h00003010, 4'b0001, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 32'h00003020, 4'b1111, 1'b0, 5'd0, 1'b0, 1'b1, 2'd2);
    check_val("tp4_valid", {30'd0, IQ_valid_o}, 32'd0);

    // Exception packet
    cyc(1'b1, 32'h80000010, 4'b0100, 1'b1, 5'h04, 1'b0, 1'b0, 2'd0);
    check_val("tp5_pc", IQ_pc0_o, 32'h80000018);
    check_val("tp5_code", {27'd0, IQ_excCode0_o}, 32'h4);
    check_val("tp5_valid", {30'd0, IQ_valid_o}, 32'd1);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd1);

    // Advance tail to 14, then stream across the wrap
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h00005000 + 32'(16 * i), 4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 32'h00005030, 4'b0001, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2);
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h00006000 + 32'(16 * i), 4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rb = {$urandom_range(0, 32'h0FFFFFFF), 4'b0000};
      cyc(($urandom_range(0, 99) < 55), rb, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 99) < 8), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 3), 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h00007000 + 32'(16 * i), 4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'h00008000, 4'b0011, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Instruction queue between the IF fetch-address stage and ID decode. Each cycle it accepts one I-Cache return of up to four instructions, qualified by the per-lane enable mask the fetch stage produced. It compacts the enabled lanes into a circular buffer and presents up to two in-order instructions per cycle to decode. It drives the `ID_stopFetch` back-pressure that gates new fetch requests, and it empties on any branch-mispredict or exception flush.

## Interface
- `DEPTH`, 16, number of entries; power of two, at least 8.
- `STOP_FREE`, 8, stop-fetch threshold; fetch stops when free entries < `STOP_FREE`. This covers two in-flight 4-instruction returns.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `IC_valid_i` input 1: an I-Cache return packet is present this cycle.
- `IC_VAddr_i` input 32: 16-byte-aligned base VA of the packet; lane k PC = base + 4k.
- `IC_inst_i` input 128: lane k occupies bits [32k+31:32k].
- `IC_instEnable_i` input 4: lanes to keep.
- `IC_hasException_i` input 1: the packet carries a fetch exception.
- `IC_ExcCode_i` input 5: exception code.
- `IC_needDelaySlot_i` input 1: the lowest enabled lane is a delay slot.
- `flush_i` input 1: OR of the mispredict flush and the CP0 exception flush.
- `ID_popNum_i` input 2: number of instructions decode consumes this cycle (0–2).
- `IQ_valid_o` output 2: bit j means output slot j holds a valid instruction.
- `IQ_inst0_o`, `IQ_inst1_o` output 32 each: instruction words.
- `IQ_pc0_o`, `IQ_pc1_o` output 32 each: instruction PCs.
- `IQ_hasExc_o` output 2, `IQ_excCode0_o`, `IQ_excCode1_o` output 5 each: exception tags per slot.
- `IQ_isDelaySlot_o` output 2: delay-slot tag per slot.
- `IQ_stopFetch_o` output 1: back-pressure to fetch (`ID_stopFetch`).
- `IQ_overflow_o` output 1: sticky error, set when a packet was dropped for lack of space.

## Operation
- Storage: `DEPTH` entries, each holding {inst 32, pc 32, hasExc 1, excCode 5, isDS 1}. Head and tail pointers are log2(DEPTH)+1 bits; the extra MSB is the wrap bit. `count` is a separate register with range 0..`DEPTH`.
- Push count: if `IC_hasException_i`, n = 1. Otherwise n = popcount(`IC_instEnable_i`).
- Normal push: enabled lanes are written in ascending lane order to tail, tail+1, and so on, modulo `DEPTH`. The isDS bit is set only on the first written entry, and only when `IC_needDelaySlot_i` = 1. Tail advances by n.
- Exception push: exactly one entry is written, with pc = `IC_VAddr_i` + 4·(index of the lowest enabled lane, or 0 if the mask is 0), inst = 0, hasExc = 1, excCode = `IC_ExcCode_i`.
- Pop: effective pop count p = min(`ID_popNum_i`, count, 2). Head advances by p.
- Space check: a push occurs only if n ≤ `DEPTH` − count, using count from before this cycle's pop. Otherwise the whole packet is dropped and `IQ_overflow_o` is set to 1. It clears only on `rst`.
- Count update: count_next = count + (pushed ? n : 0) − p.
- Output slots: slot 0 = entry[head] and slot 1 = entry[head+1]. `IQ_valid_o` = {count ≥ 2, count ≥ 1}. Every data and tag field of a slot reads 0 while its valid bit is 0.
- Stop-fetch: `IQ_stopFetch_o` = (`DEPTH` − count) < `STOP_FREE`. It is a function of registered state only.
- Flush: `flush_i` has highest priority. Head, tail and count go to 0. Any push or pop in the same cycle is ignored. `IQ_overflow_o` is unaffected.

## Timing
- Reset values: head = tail = count = 0. Every output is 0: `IQ_valid_o` = 00, all data fields 0, `IQ_stopFetch_o` = 0, `IQ_overflow_o` = 0.
- Latency: a pushed entry is visible on the outputs the cycle after the push. There is no empty-queue bypass.
- A pop takes effect at the clock edge; the next entries appear in the following cycle.
- Simultaneous push and pop are both applied in the same cycle.
- Wrap-around: indices are taken modulo `DEPTH`. A 4-lane write that straddles the end of the buffer, e.g. tail = 14 with `DEPTH` = 16, writes entries 14, 15, 0, 1.
- Full (count = `DEPTH`): slots 0 and 1 stay valid, any push with n > 0 overflows, and an n = 0 packet is a no-op.
- Asserting `rst` mid-stream clears the queue asynchronously. It must be released synchronously to `clk` by the top level.

## Configuration
- `IQ_PERF_EN` defined: adds output `IQ_stallCycles_o` (32 bits). It is reset to 0 and increments every cycle `IQ_stopFetch_o` = 1, wrapping at 2^32. Flush does not clear it.
- `IQ_PERF_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Push base 0x1FC00000, mask 1111, pop 2 per cycle → slot PCs 0x1FC00000/0x1FC00004, then 0x1FC00008/0x1FC0000C; count returns to 0.
- Push mask 1010 with the delay-slot flag set → one cycle later `IQ_valid_o` = 11, pc0 = base+4 with isDS = 1, pc1 = base+12 with isDS = 0.
- Push four packets with mask 1111 and no pops → count = 16, `IQ_stopFetch_o` = 1 from count 9 onward, and a fifth packet sets `IQ_overflow_o` = 1 with count still 16.
- With count = 5, assert `flush_i` together with a push and `ID_popNum_i` = 2 → next cycle count = 0, `IQ_valid_o` = 00, pointers = 0.
- Exception packet with base 0x80000010, mask 0100, excCode 0x04 → a single entry with pc 0x80000018, inst 0, hasExc = 1, excCode 0x04.
- Steady state: tail = 14, push 1111 and pop 1 → entries land at 14, 15, 0, 1 and the output sequence remains in order across the wrap.
